// File: rtl/loop_ctrl_pkg.sv
// Shared definitions for the loop-control sequencer.
// Contents:
//   state_t        3-bit state encoding: IDLE/SETTLE/ARM/RUN/COOL = 0..4.
//   IVEC_*         nand3 drive vectors {i0,i1,i2} per state.
//   FAULT_CNT_SAT  saturation value for the fault counter.
//   ivec_of()      maps a state to its nand3 drive vector.
package loop_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ARM    = 3'd2,
    ST_RUN    = 3'd3,
    ST_COOL   = 3'd4
  } state_t;

  // Bit order is {i0, i1, i2}: bias enable, settled, locked-and-running.
  localparam logic [2:0] IVEC_OFF    = 3'b000;
  localparam logic [2:0] IVEC_SETTLE = 3'b100;
  localparam logic [2:0] IVEC_ARM    = 3'b110;
  localparam logic [2:0] IVEC_RUN    = 3'b111;

  localparam logic [7:0] FAULT_CNT_SAT = 8'hFF;

  function automatic logic [2:0] ivec_of(input state_t s);
    logic [2:0] v;
    case (s)
      ST_SETTLE: v = IVEC_SETTLE;
      ST_ARM:    v = IVEC_ARM;
      ST_RUN:    v = IVEC_RUN;
      default:   v = IVEC_OFF;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/loop_lock_filt.sv
// Lock deglitch filter.
// lock_f follows lock_raw only after FILT_LEN consecutive samples that
// disagree with the current lock_f; any agreeing sample restarts the run.
// Ports:
//   CELCLK    clock, rising edge
//   CELRST    synchronous active-high reset (lock_f -> 0)
//   lock_raw  unfiltered lock, synchronous to CELCLK
//   lock_f    filtered lock (registered)
module loop_lock_filt #(
  parameter int FILT_LEN = 4
) (
  input  logic CELCLK,
  input  logic CELRST,
  input  logic lock_raw,
  output logic lock_f
);

  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  // The run counter never needs to hold FILT_LEN itself: the sample that
  // would make it FILT_LEN toggles lock_f and clears the counter instead.
  localparam logic [FW-1:0] RUN_LAST = FW'(FILT_LEN - 1);

  logic [FW-1:0] r_run;
  logic          r_lock_f;

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      r_run    <= '0;
      r_lock_f <= 1'b0;
    end else if (lock_raw == r_lock_f) begin
      r_run <= '0;
    end else if (r_run == RUN_LAST) begin
      r_lock_f <= lock_raw;
      r_run    <= '0;
    end else begin
      r_run <= r_run + 1'b1;
    end
  end

  assign lock_f = r_lock_f;

endmodule

// File: rtl/loop_ctrl_seq.sv
// Loop-control sequencer feeding the loop nand3 brick. The nand3 output
// only goes low (all three inputs high) in RUN: powered, settled, locked,
// fault-free.
// Optional build macro: LOOP_CTRL_SEQ_FAULT_LATCH_EN -- after a fault the
// cooldown always lands in IDLE and latches; start is then ignored until a
// stop pulse seen in IDLE clears the latch.
// Ports:
//   CELCLK, CELRST     clock / synchronous active-high reset
//   CELV, CELG, SUB    supply/ground/substrate symbol pins, no function
//   start, stop        level run / shutdown requests
//   lock_raw           unfiltered lock (already synchronous)
//   fault              fault indicator
//   i0_o, i1_o, i2_o   nand3 inputs (bias enable / settled / locked+running)
//   state_o            current state encoding
//   lock_f_o           filtered lock
//   fault_cnt_o        saturating fault count
module loop_ctrl_seq
  import loop_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int FILT_LEN   = 4,
  parameter int COOL_CYC   = 32,
  parameter int CNT_W      = 8
) (
  input  logic       CELCLK,
  input  logic       CELRST,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       start,
  input  logic       stop,
  input  logic       lock_raw,
  input  logic       fault,
  output logic       i0_o,
  output logic       i1_o,
  output logic       i2_o,
  output logic [2:0] state_o,
  output logic       lock_f_o,
  output logic [7:0] fault_cnt_o
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOL_CYC - 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_fcnt;
  logic             w_fault_hit;
  logic [2:0]       r_ivec;
  logic [2:0]       w_ivec_nxt;
  logic             w_lock_f;
  logic             w_unused_pins;

  // Symbol-only pins: folded into a dead signal so they stay on the port list.
  assign w_unused_pins = &{1'b0, CELV, CELG, SUB};

  loop_lock_filt #(
    .FILT_LEN (FILT_LEN)
  ) u_lock_filt (
    .CELCLK   (CELCLK),
    .CELRST   (CELRST),
    .lock_raw (lock_raw),
    .lock_f   (w_lock_f)
  );

`ifdef LOOP_CTRL_SEQ_FAULT_LATCH_EN
  logic r_latch;
  logic w_latch_nxt;

  always_ff @(posedge CELCLK) begin
    if (CELRST) r_latch <= 1'b0;
    else        r_latch <= w_latch_nxt;
  end
`endif

  // State register, shared counter, fault counter and registered outputs.
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_fcnt  <= '0;
      r_ivec  <= IVEC_OFF;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ivec  <= w_ivec_nxt;
      if (w_fault_hit && (r_fcnt != FAULT_CNT_SAT))
        r_fcnt <= r_fcnt + 8'd1;
    end
  end

  // Next-state logic. Priority inside an active state: fault > stop > rest.
  always_comb begin
    w_nxt       = r_state;
    w_cnt_nxt   = r_cnt;
    w_fault_hit = 1'b0;
`ifdef LOOP_CTRL_SEQ_FAULT_LATCH_EN
    w_latch_nxt = r_latch;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef LOOP_CTRL_SEQ_FAULT_LATCH_EN
        if (r_latch) begin
          // Latched: only a stop clears it; start counts from next cycle.
          if (stop) w_latch_nxt = 1'b0;
        end else if (start && !stop) begin
          w_nxt     = ST_SETTLE;
          w_cnt_nxt = '0;
        end
`else
        if (start && !stop) begin
          w_nxt     = ST_SETTLE;
          w_cnt_nxt = '0;
        end
`endif
      end
      ST_SETTLE, ST_ARM, ST_RUN: begin
        if (fault) begin
          w_nxt       = ST_COOL;
          w_cnt_nxt   = '0;
          w_fault_hit = 1'b1;
        end else if (stop) begin
          w_nxt = ST_IDLE;
        end else begin
          case (r_state)
            ST_SETTLE: begin
              // Always passes through ARM, even if lock is already good.
              if (r_cnt == SETTLE_LAST) w_nxt = ST_ARM;
              else                      w_cnt_nxt = r_cnt + 1'b1;
            end
            ST_ARM:  if (w_lock_f)  w_nxt = ST_RUN;
            default: if (!w_lock_f) w_nxt = ST_ARM;
          endcase
        end
      end
      ST_COOL: begin
        // Cooldown cannot be aborted or extended by stop/fault.
        if (r_cnt == COOL_LAST) begin
`ifdef LOOP_CTRL_SEQ_FAULT_LATCH_EN
          w_nxt       = ST_IDLE;
          w_latch_nxt = 1'b1;
`else
          if (start && !stop) begin
            w_nxt     = ST_SETTLE;
            w_cnt_nxt = '0;
          end else begin
            w_nxt = ST_IDLE;
          end
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nxt     = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs flip with state_o.
  always_comb begin
    w_ivec_nxt = ivec_of(w_nxt);
  end

  assign state_o     = r_state;
  assign i0_o        = r_ivec[2];
  assign i1_o        = r_ivec[1];
  assign i2_o        = r_ivec[0];
  assign lock_f_o    = w_lock_f;
  assign fault_cnt_o = r_fcnt;

endmodule

// File: tb/tb_loop_ctrl_seq.sv
module tb_loop_ctrl_seq;

  localparam int SETTLE_CYC = 16;
  localparam int FILT_LEN   = 4;
  localparam int COOL_CYC   = 32;

  logic       CELCLK = 1'b0;
  logic       CELRST = 1'b1;
  logic       start = 1'b0, stop = 1'b0, lock_raw = 1'b0, fault = 1'b0;
  logic       i0_o, i1_o, i2_o, lock_f_o;
  logic [2:0] state_o;
  logic [7:0] fault_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: named phases, countdown of remaining cycles in timed
  // phases, and a mismatch streak for the lock filter.
  localparam int P_IDLE = 0, P_SETTLE = 1, P_ARM = 2, P_RUN = 3, P_COOL = 4;
  int m_ph, m_left, m_fc, m_mis;
  bit m_lf, m_latch;

  always #5 CELCLK = ~CELCLK;

  loop_ctrl_seq #(
    .SETTLE_CYC (SETTLE_CYC),
    .FILT_LEN   (FILT_LEN),
    .COOL_CYC   (COOL_CYC),
    .CNT_W      (8)
  ) dut (
    .CELCLK      (CELCLK),
    .CELRST      (CELRST),
    .CELV        (1'b1),
    .CELG        (1'b0),
    .SUB         (1'b0),
    .start       (start),
    .stop        (stop),
    .lock_raw    (lock_raw),
    .fault       (fault),
    .i0_o        (i0_o),
    .i1_o        (i1_o),
    .i2_o        (i2_o),
    .state_o     (state_o),
    .lock_f_o    (lock_f_o),
    .fault_cnt_o (fault_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_ivec(input int ph);
    case (ph)
      P_SETTLE: return 3'b100;
      P_ARM:    return 3'b110;
      P_RUN:    return 3'b111;
      default:  return 3'b000;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit sp, input bit lr, input bit ft);
    bit lf_old;
    bit active;
    if (rst) begin
      m_ph = P_IDLE; m_left = 0; m_fc = 0; m_mis = 0; m_lf = 0; m_latch = 0;
      return;
    end
    lf_old = m_lf;
    if (lr == m_lf) m_mis = 0;
    else begin
      m_mis++;
      if (m_mis == FILT_LEN) begin m_lf = lr; m_mis = 0; end
    end
    active = (m_ph == P_SETTLE) || (m_ph == P_ARM) || (m_ph == P_RUN);
    if (active && ft) begin
      m_ph = P_COOL; m_left = COOL_CYC;
      if (m_fc < 255) m_fc++;
    end else if (active && sp) begin
      m_ph = P_IDLE;
    end else begin
      case (m_ph)
        P_IDLE:
          if (m_latch) begin
            if (sp) m_latch = 0;
          end else if (st && !sp) begin
            m_ph = P_SETTLE; m_left = SETTLE_CYC;
          end
        P_SETTLE: begin
          m_left--;
          if (m_left == 0) m_ph = P_ARM;
        end
        P_ARM: if (lf_old)  m_ph = P_RUN;
        P_RUN: if (!lf_old) m_ph = P_ARM;
        default: begin
          m_left--;
          if (m_left == 0) begin
`ifdef LOOP_CTRL_SEQ_FAULT_LATCH_EN
            m_ph = P_IDLE; m_latch = 1;
`else
            if (st && !sp) begin m_ph = P_SETTLE; m_left = SETTLE_CYC; end
            else m_ph = P_IDLE;
`endif
          end
        end
      endcase
    end
  endtask

  // One clock: apply inputs, step the model at the edge, compare on negedge.
  task automatic cyc(input bit rst, input bit st, input bit sp, input bit lr, input bit ft);
    CELRST = rst; start = st; stop = sp; lock_raw = lr; fault = ft;
    @(posedge CELCLK);
    model_step(rst, st, sp, lr, ft);
    @(negedge CELCLK);
    chk("state", 32'(state_o), 32'(m_ph));
    chk("ivec", 32'({i0_o, i1_o, i2_o}), 32'(exp_ivec(m_ph)));
    chk("lock_f", 32'(lock_f_o), 32'(m_lf));
    chk("fault_cnt", 32'(fault_cnt_o), 32'(m_fc));
  endtask

  initial begin
    bit lr;
    // reset
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("reset_state", 32'(state_o), 32'd0);
    // nominal start with lock from cycle 0
    repeat (30) cyc(0, 1, 0, 1, 0);
    chk("nominal_run", 32'({state_o, i0_o, i1_o, i2_o}), {26'd0, 3'd3, 3'b111});
    // lock glitches: short one ignored, long one drops to ARM, then recovers
    repeat (3) cyc(0, 1, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 1, 0);
    repeat (6) cyc(0, 1, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 1, 0);
    // single-cycle fault with start held
    cyc(0, 1, 0, 1, 1);
    repeat (40) cyc(0, 1, 0, 1, 0);
`ifdef LOOP_CTRL_SEQ_FAULT_LATCH_EN
    cyc(0, 0, 1, 1, 0);
    repeat (25) cyc(0, 1, 0, 1, 0);
`endif
    // priority: fault+stop together in ARM
    cyc(0, 0, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 0, 0);
    repeat (18) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 1);
    repeat (32) cyc(0, 1, 0, 0, 0);
`ifdef LOOP_CTRL_SEQ_FAULT_LATCH_EN
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
`endif
    // stop alone mid-SETTLE
    repeat (10) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    // saturation of the fault counter
    for (int k = 0; k < 300; k++) begin
      cyc(0, 0, 1, 0, 0);
      repeat (35) cyc(0, 1, 0, 0, 1);
    end
    chk("fault_sat", 32'(fault_cnt_o), 32'hFF);
    // reset while in COOL
    repeat (40) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_cool_state", 32'(state_o), 32'd0);
    chk("rst_cool_fcnt", 32'(fault_cnt_o), 32'd0);
    chk("rst_cool_ivec", 32'({i0_o, i1_o, i2_o}), 32'd0);
    // randomized traffic
    lr = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(5) == 0) lr = ~lr;
      cyc(($urandom_range(699) == 0), ($urandom_range(7) != 0),
          ($urandom_range(23) == 0), lr, ($urandom_range(79) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
